// File: rtl/fetch_pipeline_pkg.sv
// Shared definitions for the SimpleRisc IF stage.
// Contents: default reset PC, nop encoding, PC increment, FSM state encoding
// and the word-alignment helper used on redirect targets.
package fetch_pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h6800_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits so a redirect always lands on a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_pipeline_if.sv
// Bundle of signals between the IF stage and its neighbours.
// master: the fetch stage (drives imem_addr and the IF/OF latch outputs).
// slave : the environment (EX redirect, hazard stall, instruction memory, OF stage).
//   isBranchTaken/branch : EX redirect request and target
//   stall                : hazard unit hold request
//   imem_addr/imem_rdata : synchronous instruction memory, 1-cycle read latency
//   pc_out/instruction_out/valid_out : IF/OF latch
// Optional FETCH_STATS_EN adds fetch_count and flush_count.
interface fetch_pipeline_if;
  logic        isBranchTaken;
  logic [31:0] branch;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  modport master (
    input  isBranchTaken, branch, stall, imem_rdata,
`ifdef FETCH_STATS_EN
    output fetch_count, flush_count,
`endif
    output imem_addr, pc_out, instruction_out, valid_out
  );

  modport slave (
    output isBranchTaken, branch, stall, imem_rdata,
`ifdef FETCH_STATS_EN
    input  fetch_count, flush_count,
`endif
    input  imem_addr, pc_out, instruction_out, valid_out
  );
endinterface

// File: rtl/fetch_pipeline_skid_buffer.sv
// One-entry skid buffer holding an instruction word that returned while the
// IF/OF latch was stalled.
// Ports: clk, rst (async active-low), capture/consume/flush controls,
// data_in (word to capture), data_out/valid_out (held entry).
// Flush has priority over capture, capture over consume.
module fetch_pipeline_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid_out
);

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Next-state selection for the held entry.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_pipeline.sv
// SimpleRisc IF stage: owns the PC, drives a 1-cycle-latency instruction
// memory, fills the IF/OF latch, honours OF stall and flushes on EX redirect.
// Ports: clk, rst (async active-low), bus (fetch_pipeline_if.master).
// Parameters: RESET_PC (first fetch address), NOP_INSTR (bubble encoding).
// Optional feature macro: FETCH_STATS_EN adds fetch_count/flush_count.
module fetch_pipeline
  import fetch_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  fetch_pipeline_if.master   bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic         rsp_vld_q, rsp_vld_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;

  logic         load_latch_s;
  logic         advance_s;
  logic         skid_capture_s;
  logic         skid_consume_s;
  logic         skid_flush_s;
  logic [31:0]  skid_data_s;
  logic         skid_vld_s;
  logic [31:0]  rsp_word_s;

  fetch_pipeline_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .capture   (skid_capture_s),
    .consume   (skid_consume_s),
    .flush     (skid_flush_s),
    .data_in   (bus.imem_rdata),
    .data_out  (skid_data_s),
    .valid_out (skid_vld_s)
  );

  // A word parked in the skid belongs to rsp_pc and wins over the live bus,
  // which by then carries the word for req_pc.
  assign rsp_word_s = skid_vld_s ? skid_data_s : bus.imem_rdata;

  // FSM next state, PC/response tracking and IF/OF latch update.
  always_comb begin
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    rsp_pc_d       = rsp_pc_q;
    rsp_vld_d      = rsp_vld_q;
    pc_out_d       = pc_out_q;
    instr_d        = instr_q;
    valid_d        = valid_q;
    load_latch_s   = 1'b0;
    advance_s      = 1'b0;
    skid_capture_s = 1'b0;
    skid_consume_s = 1'b0;
    skid_flush_s   = 1'b0;

    if (bus.isBranchTaken) begin
      // Redirect beats stall: drop everything in flight and restart at target.
      req_pc_d     = align_word(bus.branch);
      rsp_vld_d    = 1'b0;
      skid_flush_s = 1'b1;
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      state_d      = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          // Nothing valid is in flight, so the latch loads a bubble regardless.
          load_latch_s = 1'b1;
          if (bus.stall) begin
            state_d = ST_HOLD;
          end else begin
            advance_s = 1'b1;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stall) begin
            state_d = ST_HOLD;
            // The word for rsp_pc arrives this cycle; park it or it is lost.
            skid_capture_s = rsp_vld_q && !skid_vld_s;
          end else begin
            load_latch_s = 1'b1;
            advance_s    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.stall) begin
            state_d = ST_HOLD;
          end else begin
            load_latch_s = 1'b1;
            advance_s    = 1'b1;
            state_d      = ST_RUN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end

    if (load_latch_s) begin
      pc_out_d       = rsp_pc_q;
      instr_d        = rsp_vld_q ? rsp_word_s : NOP_INSTR;
      valid_d        = rsp_vld_q;
      skid_consume_s = skid_vld_s;
    end else begin
      skid_consume_s = 1'b0;
    end

    if (advance_s) begin
      rsp_pc_d  = req_pc_q;
      rsp_vld_d = 1'b1;
      req_pc_d  = req_pc_q + PC_INC;   // wraps silently past 32'hFFFF_FFFC
    end else begin
      rsp_pc_d  = rsp_pc_d;
    end
  end

  // State, PC and IF/OF latch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_BOOT;
      req_pc_q  <= RESET_PC;
      rsp_pc_q  <= 32'd0;
      rsp_vld_q <= 1'b0;
      pc_out_q  <= 32'd0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      rsp_pc_q  <= rsp_pc_d;
      rsp_vld_q <= rsp_vld_d;
      pc_out_q  <= pc_out_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.imem_addr       = req_pc_q;
  assign bus.pc_out          = pc_out_q;
  assign bus.instruction_out = instr_q;
  assign bus.valid_out       = valid_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Count valid latch loads and redirect cycles; both wrap.
  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (load_latch_s && rsp_vld_q && !bus.isBranchTaken) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (bus.isBranchTaken) begin
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_pipeline.sv
module tb_fetch_pipeline;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fetch_pipeline_if bus ();
  fetch_pipeline_if bus_w ();

  fetch_pipeline u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_pipeline #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word at address a is a+1 (imem[i] = i*4+1).
  always @(posedge clk) begin
    bus.imem_rdata   <= bus.imem_addr + 32'd1;
    bus_w.imem_rdata <= bus_w.imem_addr + 32'd1;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [23];
  logic [31:0] wrap_pc [4];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_latch(input string tag, input int idx, input logic v, input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, "_valid"}, idx, {31'd0, bus.valid_out}, {31'd0, v});
    chk({tag, "_instr"}, idx, bus.instruction_out, v ? pc + 32'd1 : NOP);
    chk({tag, "_addr"}, idx, bus.imem_addr, addr);
    if (v) chk({tag, "_pc"}, idx, bus.pc_out, pc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //         stall br  target        valid pc            addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h4};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'hC};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   32'h14};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'h18};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  32'h1C};
    vecs[10] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h100};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h108};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 32'h10C};
    vecs[14] = '{1'b1, 1'b1, 32'h203, 1'b0, 32'h0,   32'h200};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h204};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h208};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 32'h20C};
    vecs[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 32'h20C};
    vecs[19] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   32'h300};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h304};
    vecs[21] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 32'h308};
    vecs[22] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 32'h30C};
    wrap_pc[0] = 32'h0;
    wrap_pc[1] = 32'hFFFF_FFF8;
    wrap_pc[2] = 32'hFFFF_FFFC;
    wrap_pc[3] = 32'h0000_0000;

    rst = 1'b0;
    bus.stall = 1'b0;   bus.isBranchTaken = 1'b0;   bus.branch = 32'd0;
    bus_w.stall = 1'b0; bus_w.isBranchTaken = 1'b0; bus_w.branch = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_latch("reset", -1, 1'b0, 32'd0, 32'd0);
    chk("reset_pc_out", -1, bus.pc_out, 32'd0);
    chk("reset_wrap_addr", -1, bus_w.imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
    chk("reset_fetch_count", -1, bus.fetch_count, 32'd0);
    chk("reset_flush_count", -1, bus.flush_count, 32'd0);
`endif
    rst = 1'b1;

    for (int k = 0; k < 23; k++) begin
      bus.stall         = vecs[k].stall;
      bus.isBranchTaken = vecs[k].br;
      bus.branch        = vecs[k].target;
      @(posedge clk);
      #1;
      chk_latch("vec", k, vecs[k].exp_valid, vecs[k].exp_pc, vecs[k].exp_addr);
      if (k >= 1 && k <= 3) begin
        chk("wrap_valid", k, {31'd0, bus_w.valid_out}, 32'd1);
        chk("wrap_pc", k, bus_w.pc_out, wrap_pc[k]);
        chk("wrap_instr", k, bus_w.instruction_out, wrap_pc[k] + 32'd1);
      end
    end
    bus.isBranchTaken = 1'b0;
`ifdef FETCH_STATS_EN
    chk("run_fetch_count", 22, bus.fetch_count, 32'd12);
    chk("run_flush_count", 22, bus.flush_count, 32'd3);
`endif

    // Reset asserted mid-HOLD with the skid holding the word for 0x308.
    bus.stall = 1'b1;
    @(posedge clk); #1;
    chk_latch("hold_enter", 23, 1'b1, 32'h304, 32'h30C);
    @(posedge clk); #1;
    chk_latch("hold_stay", 24, 1'b1, 32'h304, 32'h30C);
    #2 rst = 1'b0;
    #1;
    chk_latch("async_reset", 25, 1'b0, 32'd0, 32'd0);
    chk("async_reset_pc_out", 25, bus.pc_out, 32'd0);
`ifdef FETCH_STATS_EN
    chk("async_reset_fetch_count", 25, bus.fetch_count, 32'd0);
    chk("async_reset_flush_count", 25, bus.flush_count, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    // Stall held through BOOT: PC must not move.
    @(posedge clk); #1;
    chk_latch("boot_stall", 26, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk_latch("boot_hold", 27, 1'b0, 32'd0, 32'd0);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    chk_latch("refetch0", 28, 1'b0, 32'd0, 32'd4);
    @(posedge clk); #1;
    chk_latch("refetch1", 29, 1'b1, 32'd0, 32'd8);
    @(posedge clk); #1;
    chk_latch("refetch2", 30, 1'b1, 32'd4, 32'hC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
